// File: rtl/uart_tx_engine.sv
// UART transmitter: frames din as start, DBIT data bits (LSB first), optional parity, stop.
// Timing is counted in s_tick pulses (16 per bit); tx is registered, tx_done_tick marks the final stop tick.
module uart_tx_engine #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int PARITY  = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_tick,
  input  logic            tx_start,
  input  logic [DBIT-1:0] din,
  output logic            tx,
  output logic            busy,
  output logic            tx_done_tick
);

  localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [SW-1:0] S_LAST_BIT  = SW'(15);
  localparam logic [SW-1:0] S_LAST_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            par_q, par_d;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    tx_d    = tx_q;
    par_d   = par_q;

    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (tx_start) begin
          state_d = ST_START;
          b_d     = din;
          s_d     = '0;
          // Parity is taken from din here because b shifts away its bits during DATA.
          par_d   = (^din) ^ (PARITY == 2);
          tx_d    = 1'b0;
        end
      end

      ST_START: begin
        if (s_tick) begin
          if (s_q == S_LAST_BIT) begin
            state_d = ST_DATA;
            s_d     = '0;
            n_d     = '0;
            tx_d    = b_q[0];
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end

      ST_DATA: begin
        if (s_tick) begin
          if (s_q == S_LAST_BIT) begin
            s_d = '0;
            b_d = b_q >> 1;
            if (n_q == N_LAST) begin
              if (PARITY != 0) begin
                state_d = ST_PAR;
                tx_d    = par_q;
              end else begin
                state_d = ST_STOP;
                tx_d    = 1'b1;
              end
            end else begin
              n_d  = n_q + NW'(1);
              tx_d = b_q[1];
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end

      ST_PAR: begin
        if (s_tick) begin
          if (s_q == S_LAST_BIT) begin
            state_d = ST_STOP;
            s_d     = '0;
            tx_d    = 1'b1;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end

      ST_STOP: begin
        if (s_tick) begin
          if (s_q == S_LAST_STOP) begin
            state_d = ST_IDLE;
            s_d     = '0;
            tx_d    = 1'b1;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      par_q   <= par_d;
    end
  end

  // Done is decoded from the final stop tick so the next word can be accepted one clk later.
  assign tx_done_tick = (state_q == ST_STOP) && s_tick && (s_q == S_LAST_STOP);
  assign tx           = tx_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: four instances cover no/even/odd parity and a two-bit stop.
module tb_uart_tx_engine;

  logic       clk;
  logic       rst;
  logic       s_tick;
  logic       tx_start;
  logic [7:0] din;
  logic [3:0] tx_w;
  logic [3:0] busy_w;
  logic [3:0] done_w;

  int n_cmp = 0;
  int n_bad = 0;

  uart_tx_engine #(.DBIT(8), .SB_TICK(16), .PARITY(0)) u_p0 (
    .clk(clk), .rst(rst), .s_tick(s_tick), .tx_start(tx_start), .din(din),
    .tx(tx_w[0]), .busy(busy_w[0]), .tx_done_tick(done_w[0]));
  uart_tx_engine #(.DBIT(8), .SB_TICK(16), .PARITY(1)) u_even (
    .clk(clk), .rst(rst), .s_tick(s_tick), .tx_start(tx_start), .din(din),
    .tx(tx_w[1]), .busy(busy_w[1]), .tx_done_tick(done_w[1]));
  uart_tx_engine #(.DBIT(8), .SB_TICK(16), .PARITY(2)) u_odd (
    .clk(clk), .rst(rst), .s_tick(s_tick), .tx_start(tx_start), .din(din),
    .tx(tx_w[2]), .busy(busy_w[2]), .tx_done_tick(done_w[2]));
  uart_tx_engine #(.DBIT(8), .SB_TICK(32), .PARITY(0)) u_sb2 (
    .clk(clk), .rst(rst), .s_tick(s_tick), .tx_start(tx_start), .din(din),
    .tx(tx_w[3]), .busy(busy_w[3]), .tx_done_tick(done_w[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // seq0/seq1: hand-computed line bits in send order (start, data, parity), bit i = i-th bit.
  // Each frame lasts T*div clks; with hold, tx_start stays high so frame 2 starts after one idle clk.
  task automatic run_frame(input string name, input int w, input int nf,
                           input logic [7:0] d0, input logic [7:0] d1,
                           input logic [9:0] seq0, input logic [9:0] seq1,
                           input int nb, input int sb, input int div,
                           input int glitch_c, input bit rel_rst);
    int t_clks, per;
    int tx_bad, busy_bad, done_bad, busy_cnt, done_cnt, first_bad;
    logic [9:0] seq;
    logic etx, ebusy, edone;
    t_clks = (16 * nb + sb) * div;
    per = t_clks + 1;
    tx_bad = 0; busy_bad = 0; done_bad = 0; busy_cnt = 0; done_cnt = 0; first_bad = -1;
    for (int c = 0; c <= nf * per; c++) begin
      int k, cc, j;
      @(negedge clk);
      k  = (c == 0) ? 0 : (c - 1) / per;
      cc = c - k * per;
      if (c == 0) begin
        tx_start = 1'b1;
        din      = d0;
        s_tick   = 1'b0;
        if (rel_rst) rst = 1'b0;
      end else begin
        tx_start = (k < nf - 1);
        din      = (k < nf - 1) ? d1 : ~((k == 0) ? d0 : d1);
        s_tick   = (cc <= t_clks) && (cc % div == 0);
        if (c == glitch_c) begin
          tx_start = 1'b1;
          din      = 8'hFF;
        end
      end
      #1;
      if (c > 0) begin
        seq = (k == 0) ? seq0 : seq1;
        if (cc == per) begin
          etx = 1'b1; ebusy = 1'b0; edone = 1'b0;
        end else begin
          j     = (cc - 1) / (16 * div);
          etx   = (j < nb) ? seq[j] : 1'b1;
          ebusy = 1'b1;
          edone = (cc == t_clks);
        end
        if (tx_w[w] !== etx) begin
          tx_bad++;
          if (first_bad < 0) first_bad = c;
        end
        if (busy_w[w] !== ebusy) busy_bad++;
        if (done_w[w] !== edone) done_bad++;
        if (busy_w[w] === 1'b1) busy_cnt++;
        if (done_w[w] === 1'b1) done_cnt++;
      end
    end
    tx_start = 1'b0;

    n_cmp++;
    if (tx_bad !== 0) begin
      n_bad++;
      $display("FAIL %s tx_seq: %0d wrong clks (first at clk %0d), required 0", name, tx_bad, first_bad);
    end
    n_cmp++;
    if (busy_bad !== 0) begin
      n_bad++;
      $display("FAIL %s busy_shape: %0d wrong clks, required 0", name, busy_bad);
    end
    n_cmp++;
    if (done_bad !== 0) begin
      n_bad++;
      $display("FAIL %s done_timing: %0d wrong clks, required 0", name, done_bad);
    end
    n_cmp++;
    if (busy_cnt !== nf * t_clks) begin
      n_bad++;
      $display("FAIL %s busy_count: got %0d, required %0d", name, busy_cnt, nf * t_clks);
    end
    n_cmp++;
    if (done_cnt !== nf) begin
      n_bad++;
      $display("FAIL %s done_count: got %0d, required %0d", name, done_cnt, nf);
    end
  endtask

  task automatic settle();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      tx_start = 1'b0;
      s_tick   = 1'b1;
    end
    @(negedge clk);
    s_tick = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tx_start = 1'b0; s_tick = 1'b0; din = 8'h00;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (tx_w !== 4'hF) begin
      n_bad++;
      $display("FAIL reset_tx: got %b, required 1111", tx_w);
    end
    n_cmp++;
    if (busy_w !== 4'h0) begin
      n_bad++;
      $display("FAIL reset_busy: got %b, required 0000", busy_w);
    end
    n_cmp++;
    if (done_w !== 4'h0) begin
      n_bad++;
      $display("FAIL reset_done: got %b, required 0000", done_w);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({tx_w[0], busy_w[0]} !== 2'b10) begin
      n_bad++;
      $display("FAIL idle_after_reset: tx,busy got %b, required 10", {tx_w[0], busy_w[0]});
    end
  endtask

  task automatic test_reset_midframe();
    int dcnt;
    dcnt = 0;
    @(negedge clk);
    tx_start = 1'b1; din = 8'hA5; s_tick = 1'b0;
    // Line bit 4 is data bit 3; clk 72 sits in its middle with s_tick every clk.
    for (int c = 1; c <= 72; c++) begin
      @(negedge clk);
      tx_start = 1'b0; din = 8'h00; s_tick = 1'b1;
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (tx_w[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL midframe_rst_tx: got %b, required 1", tx_w[0]);
    end
    n_cmp++;
    if (busy_w[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL midframe_rst_busy: got %b, required 0", busy_w[0]);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      if (done_w[0] === 1'b1) dcnt++;
    end
    n_cmp++;
    if (dcnt !== 0) begin
      n_bad++;
      $display("FAIL midframe_rst_done: got %0d pulses, required 0", dcnt);
    end
    run_frame("after_rst_3C", 0, 1, 8'h3C, 8'h00, 10'b0001111000, 10'b0, 9, 16, 1, 0, 1'b1);
  endtask

  initial begin
    test_reset();
    run_frame("p0_A5", 0, 1, 8'hA5, 8'h00, 10'b0101001010, 10'b0, 9, 16, 1, 0, 1'b0);
    settle();
    run_frame("even_07", 1, 1, 8'h07, 8'h00, 10'b1000001110, 10'b0, 10, 16, 1, 0, 1'b0);
    settle();
    run_frame("odd_07", 2, 1, 8'h07, 8'h00, 10'b0000001110, 10'b0, 10, 16, 1, 0, 1'b0);
    settle();
    run_frame("div4_glitch_5A", 0, 1, 8'h5A, 8'h00, 10'b0010110100, 10'b0, 9, 16, 4, 200, 1'b0);
    settle();
    test_reset_midframe();
    settle();
    run_frame("b2b_sb32", 3, 2, 8'h81, 8'hC3, 10'b0100000010, 10'b0110000110, 9, 32, 1, 0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
